// File: rtl/conv_encoder_k3.sv
// conv_encoder_k3: rate-1/2 K=3 convolutional encoder with valid/ready framing; define ENC_TAIL_EN to append 2 zero tail pairs
module conv_encoder_k3 #(
    parameter int         FRAME_LEN = 16,
    parameter logic [2:0] G0        = 3'b111,
    parameter logic [2:0] G1        = 3'b101
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       in_valid,
    input  logic       in_bit,
    output logic       in_ready,
    output logic       out_valid,
    output logic [1:0] out_pair,
    output logic       out_last,
    input  logic       out_ready,
    output logic       busy,
    output logic       done
);
    localparam int CW = $clog2(FRAME_LEN + 1);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DATA  = 2'd1;
    localparam logic [1:0] TAIL  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          s1, s0;
    logic          slot_free, load, u, last_bit, last_pair;
    logic [2:0]    w;

    assign slot_free = !out_valid || out_ready;
    assign in_ready  = (state == DATA) && slot_free;
    assign busy      = state != IDLE;
    assign done      = (state == DRAIN) && out_valid && out_ready && out_last;
    assign last_bit  = cnt == CW'(FRAME_LEN - 1);
    assign u         = (state == DATA) ? in_bit : 1'b0;
    assign w         = {u, s1, s0};
    assign load      = (state == DATA) ? (in_valid && slot_free) : ((state == TAIL) && slot_free);

`ifdef ENC_TAIL_EN
    logic tail_cnt;
    assign last_pair = (state == TAIL) && tail_cnt;

    // counts the two tail pairs; wraps back to 0 after the second
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        tail_cnt <= 1'b0;
        else if (state == IDLE)         tail_cnt <= 1'b0;
        else if (state == TAIL && load) tail_cnt <= !tail_cnt;
    end
`else
    assign last_pair = (state == DATA) && last_bit;
`endif

    // frame sequencing and data bit counting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= DATA;
                    cnt   <= '0;
                end
                DATA: if (load) begin
                    cnt <= cnt + 1'b1;
`ifdef ENC_TAIL_EN
                    if (last_bit) state <= TAIL;
`else
                    if (last_bit) state <= DRAIN;
`endif
                end
`ifdef ENC_TAIL_EN
                TAIL: if (load && tail_cnt) state <= DRAIN;
`else
                TAIL: state <= IDLE;
`endif
                DRAIN: if (done) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // encoder memory: cleared on start, shifted on every encode step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s0 <= 1'b0;
        end else if (state == IDLE && start) begin
            s1 <= 1'b0;
            s0 <= 1'b0;
        end else if (load) begin
            s1 <= u;
            s0 <= s1;
        end
    end

    // single-entry output register, holds while downstream stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_pair  <= 2'b00;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_pair  <= {^(w & G0), ^(w & G1)};
            out_last  <= last_pair;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_conv_encoder_k3.sv
// tb_conv_encoder_k3: scoreboard bench for conv_encoder_k3 (FRAME_LEN=4), follows ENC_TAIL_EN
module tb_conv_encoder_k3;
`ifdef ENC_TAIL_EN
    localparam int NP = 6;
`else
    localparam int NP = 4;
`endif
    logic       clk = 0, rst = 1, start = 0, in_valid = 0, in_bit = 0, out_ready = 1;
    logic       in_ready, out_valid, out_last, busy, done;
    logic [1:0] out_pair;
    logic [2:0] q[$];
    logic [2:0] e;
    logic [1:0] seq_a [6];
    logic [1:0] seq_b [6];
    int n_checks = 0, n_fail = 0, n_done = 0;

    conv_encoder_k3 #(.FRAME_LEN(4)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_bit(in_bit),
        .in_ready(in_ready), .out_valid(out_valid), .out_pair(out_pair), .out_last(out_last),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // monitor: pop and compare on every output handshake
    always @(negedge clk) begin
        if (!rst) begin
            if (done) n_done++;
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("unexpected pair", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("out_pair", int'(out_pair), int'(e[2:1]));
                    chk("out_last", int'(out_last), int'(e[0]));
                    chk("done", int'(done), int'(e[0]));
                end
            end
        end
    end

    task automatic push_frame(input logic [1:0] s [6]);
        for (int i = 0; i < NP; i++) q.push_back({s[i], i == NP - 1});
    endtask

    task automatic pulse_start();
        start = 1;
        @(posedge clk); #1;
        start = 0;
    endtask

    // b[i] is the i-th bit sent; gap inserts an idle cycle with a stray start after each bit
    task automatic send_range(input logic [3:0] b, input int lo, input int hi, input bit gap);
        for (int i = lo; i <= hi; i++) begin
            int t = 0;
            bit acc = 0;
            in_valid = 1;
            in_bit = b[i];
            while (!acc && t < 50) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk); #1;
                t++;
            end
            if (!acc) chk("accept timeout", 0, 1);
            in_valid = 0;
            if (gap) begin
                start = 1;
                @(posedge clk); #1;
                start = 0;
            end
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("busy after frame", int'(busy), 0);
        chk("queue drained", q.size(), 0);
    endtask

    task automatic wait_last();
        int t = 0;
        while (!(out_valid && out_last) && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("last pair reached", int'(out_valid && out_last), 1);
    endtask

    initial begin
        // 1,0,1,1 -> 11,10,00,01 then tail 01,11 ; 0,1,1,0 -> 00,11,01,01 then tail 11,00
        seq_a = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
        seq_b = '{2'b00, 2'b11, 2'b01, 2'b01, 2'b11, 2'b00};
        repeat (2) @(posedge clk);
        #1;
        chk("rst in_ready", int'(in_ready), 0);
        chk("rst out_valid", int'(out_valid), 0);
        chk("rst out_pair", int'(out_pair), 0);
        chk("rst out_last", int'(out_last), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
        for (int f = 0; f < 2; f++) begin
            push_frame(seq_a);
            pulse_start();
            send_range(4'b1101, 0, 3, 0);
            wait_idle();
        end
        push_frame(seq_a);
        pulse_start();
        send_range(4'b1101, 0, 0, 0);
        out_ready = 0;
        in_valid = 1;
        in_bit = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("stall out_valid", int'(out_valid), 1);
            chk("stall out_pair", int'(out_pair), 3);
            chk("stall in_ready", int'(in_ready), 0);
            @(posedge clk); #1;
        end
        out_ready = 1;
        send_range(4'b1101, 1, 3, 0);
        wait_idle();
        push_frame(seq_b);
        pulse_start();
        send_range(4'b0110, 0, 3, 1);
        wait_idle();
        q.push_back({2'b11, 1'b0});
        pulse_start();
        send_range(4'b1101, 0, 1, 0);
        rst = 1;
        #1;
        chk("mid rst out_valid", int'(out_valid), 0);
        chk("mid rst out_pair", int'(out_pair), 0);
        chk("mid rst in_ready", int'(in_ready), 0);
        chk("mid rst busy", int'(busy), 0);
        chk("mid rst out_last", int'(out_last), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        chk("mid rst queue", q.size(), 0);
        @(posedge clk); #1;
        push_frame(seq_a);
        pulse_start();
        send_range(4'b1101, 0, 3, 0);
        wait_idle();
        push_frame(seq_a);
        pulse_start();
        send_range(4'b1101, 0, 3, 0);
        wait_last();
        out_ready = 0;
        pulse_start();
        @(posedge clk); #1;
        chk("drain hold valid", int'(out_valid), 1);
        chk("drain hold last", int'(out_last), 1);
        chk("drain busy", int'(busy), 1);
        out_ready = 1;
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        chk("done pulse count", n_done, 6);
        chk("no extra frame", int'(busy), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/conv_encoder_k3.md
Name: conv_encoder_k3

Overview:
- Rate-1/2, constraint-length-3 convolutional encoder.
- Transmit-side counterpart of the Viterbi decoder datapath, which includes the branch-metric units.
- Accepts a frame of serial data bits over a valid/ready handshake and emits one 2-bit code pair per input bit.
- Optionally appends 2 zero tail bits so the trellis terminates in state 0, as the decoder traceback expects.

Parameters:
- FRAME_LEN, 16: data bits per frame; legal range 1..1023.
- G0, 3'b111: generator polynomial for out_pair[1]. Bit 2 taps the current input, bit 1 taps s1, bit 0 taps s0.
- G1, 3'b101: generator polynomial for out_pair[0]. Same tap ordering as G0.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a frame. Honoured only in IDLE.
- in_valid  input  1  in_bit is valid this cycle.
- in_bit  input  1  serial data bit.
- in_ready  output  1  encoder accepts in_bit this cycle.
- out_valid  output  1  out_pair holds a valid code pair.
- out_pair  output  2  [1] = G0 parity, [0] = G1 parity.
- out_last  output  1  qualifies the final pair of the frame.
- out_ready  input  1  downstream accepts out_pair this cycle.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when the last pair is accepted.

Behaviour:
- Reset (asynchronous, any time including mid-frame):
  - state = IDLE; shift register {s1,s0} = 00; bit counter = 0.
  - All outputs 0: in_ready, out_valid, out_pair = 2'b00, out_last, busy, done.
  - No partial frame survives reset.
- Encoding:
  - Window w = {u, s1, s0}, where u is the current bit, s1 the previous bit, s0 the bit before that.
  - out_pair[1] = XOR-reduce(w & G0); out_pair[0] = XOR-reduce(w & G1).
  - On each encode step: s1 <= u; s0 <= s1.
- Output register:
  - Single-entry, registered; latency from accepted input to out_valid = 1 cycle.
  - slot_free = !out_valid || out_ready.
  - While out_valid=1 and out_ready=0: out_pair, out_last and out_valid hold stable.
  - out_valid clears on handshake unless a new pair is loaded in the same cycle. Full throughput is 1 pair/cycle.
- FSM states and transitions:
  - IDLE: waits for start. On start: {s1,s0} = 00, counter = 0, go to DATA. start in any other state is ignored.
  - DATA:
    - in_ready = slot_free.
    - On in_valid && in_ready: encode in_bit, load the pair, increment the counter.
    - When the FRAME_LEN-th bit is accepted, go to TAIL (ENC_TAIL_EN defined) or DRAIN (macro undefined).
    - in_valid while in_ready=0 is ignored and the bit is not consumed.
  - TAIL:
    - in_ready = 0.
    - Whenever slot_free: encode u = 0 and load the pair.
    - Exactly 2 tail pairs; the second sets out_last = 1. Then go to DRAIN.
  - DRAIN:
    - in_ready = 0.
    - On out_valid && out_ready && out_last: done = 1 for that one cycle, go to IDLE.
    - Shift register ends at 00 when tail is enabled.
- out_last is 0 on every pair except the final pair of the frame.
- Counter width is clog2(FRAME_LEN+1). No wrap is possible, because the count stops at FRAME_LEN.
- FRAME_LEN = 1 is legal: DATA lasts for exactly one accepted bit.

Optional Feature:
- Macro: ENC_TAIL_EN.
- Defined: 2 zero tail pairs follow the data. The frame is FRAME_LEN+2 pairs and out_last is on the final tail pair.
- Undefined: there is no TAIL state. The frame is FRAME_LEN pairs and out_last is on the last data pair. The shift register is left unflushed but is cleared by the next start.

Test Plan:
- ENC_TAIL_EN defined, FRAME_LEN=4, bits 1,0,1,1, out_ready held 1 -> out_pair sequence 11,10,00,01,01,11; out_last only on the 6th pair; done pulses the cycle that pair is accepted; busy returns to 0.
- Same stimulus with ENC_TAIL_EN undefined -> 11,10,00,01; out_last on the 4th pair; done follows; a second frame of 1,0,1,1 again starts with 11.
- Backpressure: out_ready=0 for 5 cycles after the first pair -> out_pair holds 11 with out_valid=1; in_ready=0; no bit consumed; the sequence is unchanged once released.
- in_valid toggling 1/0 every cycle with out_ready=1 -> pairs emitted only for accepted bits; sequence matches the bit-exact encoder model.
- rst asserted mid-frame after 2 bits -> all outputs 0 immediately; a new start with 1,0,1,1 yields 11,10,00,01,... (no stale state).
- start pulsed during DATA and during DRAIN -> ignored; frame length and pair count unchanged.
